cache_fill_ctrl: RTL

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

---
 rtl/cache_fill_pkg.sv | 16 +
 rtl/cache_fill_ctrl.sv | 109 ++++++++++
 2 files changed

// File: rtl/cache_fill_pkg.sv
// Shared state encoding and default geometry for the cache line fill controller.
package cache_fill_pkg;

    localparam int DEF_BIT_WIDTH      = 16;
    localparam int DEF_ADDR_WIDTH     = 3;
    localparam int DEF_LINE_LOG       = 1;
    localparam int DEF_MEM_ADDR_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } fill_state_e;

endpackage

// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller: issues one burst read per miss and streams the line into RAM.
// Define CRITICAL_WORD_FIRST_EN to start the burst at the missed word and wrap within the line.
module cache_fill_ctrl
    import cache_fill_pkg::*;
#(
    parameter int BIT_WIDTH      = DEF_BIT_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int LINE_LOG       = DEF_LINE_LOG,
    parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           gwe,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [MEM_ADDR_WIDTH-1:0]      req_addr,
    input  logic [ADDR_WIDTH-LINE_LOG-1:0] req_index,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [MEM_ADDR_WIDTH-1:0]      mem_req_addr,
    input  logic                           mem_rsp_valid,
    output logic                           mem_rsp_ready,
    input  logic [BIT_WIDTH-1:0]           mem_rsp_data,
    output logic                           ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_wsel,
    output logic [BIT_WIDTH-1:0]           ram_wdata,
    output logic                           busy,
    output logic                           done
);

    localparam int LINE_W = ADDR_WIDTH - LINE_LOG;
    localparam logic [MEM_ADDR_WIDTH-1:0] OFFSET_MASK =
        {{(MEM_ADDR_WIDTH-LINE_LOG){1'b0}}, {LINE_LOG{1'b1}}};

    fill_state_e                r_state;
    fill_state_e                w_next;
    logic [MEM_ADDR_WIDTH-1:0]  r_addr;
    logic [LINE_W-1:0]          r_index;
    logic [LINE_LOG-1:0]        r_cnt;
    logic                       r_ram_we;
    logic [ADDR_WIDTH-1:0]      r_wsel;
    logic [BIT_WIDTH-1:0]       r_wdata;

    logic [MEM_ADDR_WIDTH-1:0]  w_req_base;
    logic [LINE_LOG-1:0]        w_off;
    logic                       w_rsp_take;
    logic                       w_last;

    // The latched address already carries the burst start, so its low bits double as the first offset.
`ifdef CRITICAL_WORD_FIRST_EN
    assign w_req_base = req_addr;
`else
    assign w_req_base = req_addr & ~OFFSET_MASK;
`endif

    assign w_off      = r_addr[LINE_LOG-1:0] + r_cnt;
    assign w_rsp_take = (r_state == ST_DATA) && gwe && mem_rsp_valid;
    assign w_last     = (r_cnt == {LINE_LOG{1'b1}});

    always_comb begin
        w_next = r_state;
        if (gwe) begin
            case (r_state)
                ST_IDLE: if (req_valid)            w_next = ST_ADDR;
                ST_ADDR: if (mem_req_ready)        w_next = ST_DATA;
                ST_DATA: if (w_rsp_take && w_last) w_next = ST_DONE;
                // Linger until the final registered write has drained, so done trails it.
                ST_DONE: if (!r_ram_we)            w_next = ST_IDLE;
                default:                           w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_index  <= '0;
            r_cnt    <= '0;
            r_ram_we <= 1'b0;
            r_wsel   <= '0;
            r_wdata  <= '0;
        end else if (gwe) begin
            r_state  <= w_next;
            r_ram_we <= w_rsp_take;
            if ((r_state == ST_IDLE) && req_valid) begin
                r_addr  <= w_req_base;
                r_index <= req_index;
                r_cnt   <= '0;
            end
            if (w_rsp_take) begin
                r_cnt   <= r_cnt + LINE_LOG'(1);
                r_wsel  <= {r_index, w_off};
                r_wdata <= mem_rsp_data;
            end
        end
    end

    assign req_ready     = (r_state == ST_IDLE);
    assign busy          = (r_state != ST_IDLE);
    assign mem_req_valid = (r_state == ST_ADDR);
    assign mem_req_addr  = r_addr;
    assign mem_rsp_ready = (r_state == ST_DATA) && gwe;
    assign ram_we        = r_ram_we && gwe;
    assign ram_wsel      = r_wsel;
    assign ram_wdata     = r_wdata;
    assign done          = (r_state == ST_DONE) && !r_ram_we;

endmodule
